// File: rtl/bldc_commutation_ctrl.sv
// Six-step BLDC commutation sequencer.
// Turns synchronised hall states, a direction and a duty value into the six
// gate enables {AH,BH,CH,AL,BL,CL}. The high side is PWM-gated and the low
// side is held on. Every new conducting pattern is preceded by an all-off
// dead-time gap.
// Run, brake and fault are sequenced by a two-process FSM. The FSM state is
// exposed on `state`.
// Handshake: there is no valid/ready pair. enable/brake/dir/duty are levels
// sampled every pclk, and clear_fault is a single-cycle pulse.
module bldc_commutation_ctrl #(
    parameter int clk_freq_hz      = 54_000_000,
    parameter int pwm_freq_hz      = 100_000,
    parameter int dead_time_cycles = 27,
    parameter int duty_width       = $clog2(clk_freq_hz / pwm_freq_hz) + 1
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  enable,
    input  logic                  brake,
    input  logic                  dir,
    input  logic [duty_width-1:0] duty,
    input  logic                  clear_fault,
    input  logic [2:0]            hall_values,
    output logic [5:0]            phase_enable,
    output logic [2:0]            state,
    output logic                  fault,
    output logic                  pwm_sync
);

    localparam int pwm_period = clk_freq_hz / pwm_freq_hz;
    localparam int cnt_w      = (pwm_period > 1) ? $clog2(pwm_period) : 1;
    localparam int dead_w     = (dead_time_cycles > 1) ? $clog2(dead_time_cycles) : 1;

    localparam logic [cnt_w-1:0]  pwm_last  = cnt_w'(pwm_period - 1);
    localparam logic [dead_w-1:0] dead_load = dead_w'(dead_time_cycles - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DEAD  = 3'd1,
        S_RUN   = 3'd2,
        S_BRAKE = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    logic [2:0]            hall_meta;
    logic [2:0]            hall_s;
    logic                  inv_prev_q;
    logic [cnt_w-1:0]      pwm_cnt;
    logic [duty_width-1:0] duty_q;

    state_t                state_q;
    state_t                state_d;
    logic                  tgt_brake_q;   // 1: DEAD ends in BRAKE, 0: DEAD ends in RUN
    logic                  tgt_brake_d;
    logic [dead_w-1:0]     dead_cnt_q;
    logic [dead_w-1:0]     dead_cnt_d;
    logic [5:0]            run_pat_q;     // pattern latched on RUN entry
    logic [5:0]            run_pat_d;
    logic [5:0]            phase_d;

    logic [5:0]            cw_pat;
    logic [5:0]            cur_pat;
    logic                  hall_invalid;
    logic [duty_width-1:0] duty_eff;
    logic                  pwm_on;
    logic                  running;

    // Two-flop synchroniser for the asynchronous hall inputs.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            hall_meta  <= 3'b000;
            hall_s     <= 3'b000;
            inv_prev_q <= 1'b0;
        end else begin
            hall_meta  <= hall_values;
            hall_s     <= hall_meta;
            inv_prev_q <= hall_invalid;
        end
    end

    // Free-running PWM counter, the period-start pulse and duty sampling at count 0.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            pwm_cnt  <= '0;
            pwm_sync <= 1'b0;
            duty_q   <= '0;
        end else begin
            pwm_cnt  <= (pwm_cnt == pwm_last) ? '0 : pwm_cnt + 1'b1;
            pwm_sync <= (pwm_cnt == pwm_last);
            if (pwm_cnt == '0) begin
                duty_q <= duty;
            end
        end
    end

    // Hall/direction to commutation pattern; CCW swaps high and low phases.
    always_comb begin
        cw_pat = 6'b000_000;
        case (hall_s)
            3'b101:  cw_pat = 6'b100_010;  // AH/BL
            3'b100:  cw_pat = 6'b100_001;  // AH/CL
            3'b110:  cw_pat = 6'b010_001;  // BH/CL
            3'b010:  cw_pat = 6'b010_100;  // BH/AL
            3'b011:  cw_pat = 6'b001_100;  // CH/AL
            3'b001:  cw_pat = 6'b001_010;  // CH/BL
            default: cw_pat = 6'b000_000;
        endcase
        cur_pat      = dir ? {cw_pat[2:0], cw_pat[5:3]} : cw_pat;
        hall_invalid = (hall_s == 3'b000) || (hall_s == 3'b111);
        // At count 0 the new duty value already governs this period.
        duty_eff     = (pwm_cnt == '0) ? duty : duty_q;
        pwm_on       = 32'(pwm_cnt) < 32'(duty_eff);
        running      = (state_q == S_RUN) || ((state_q == S_DEAD) && !tgt_brake_q);
    end

    // FSM next state, dead-time counter and next gate pattern.
    always_comb begin
        state_d     = state_q;
        tgt_brake_d = tgt_brake_q;
        dead_cnt_d  = dead_cnt_q;
        run_pat_d   = run_pat_q;
        phase_d     = 6'b000_000;

        if ((state_q != S_FAULT) && running && hall_invalid && inv_prev_q) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (brake) begin
                        state_d     = S_DEAD;
                        tgt_brake_d = 1'b1;
                        dead_cnt_d  = dead_load;
                    end else if (enable) begin
                        if (hall_invalid) begin
                            state_d = S_FAULT;
                        end else begin
                            state_d     = S_DEAD;
                            tgt_brake_d = 1'b0;
                            dead_cnt_d  = dead_load;
                        end
                    end
                end
                S_RUN: begin
                    if (brake) begin
                        state_d     = S_DEAD;
                        tgt_brake_d = 1'b1;
                        dead_cnt_d  = dead_load;
                    end else if (!enable) begin
                        state_d = S_IDLE;
                    end else if (cur_pat != run_pat_q) begin
                        state_d     = S_DEAD;
                        tgt_brake_d = 1'b0;
                        dead_cnt_d  = dead_load;
                    end
                end
                S_DEAD: begin
                    if (!tgt_brake_q && brake) begin
                        tgt_brake_d = 1'b1;
                        dead_cnt_d  = dead_load;
                    end else if (!tgt_brake_q && !enable) begin
                        state_d = S_IDLE;
                    end else if (dead_cnt_q == '0) begin
                        if (tgt_brake_q) begin
                            state_d = S_BRAKE;
                        end else begin
                            state_d   = S_RUN;
                            run_pat_d = cur_pat;
                        end
                    end else begin
                        dead_cnt_d = dead_cnt_q - 1'b1;
                    end
                end
                S_BRAKE: begin
                    if (!brake) begin
                        state_d = S_IDLE;
                    end
                end
                S_FAULT: begin
                    if (clear_fault && !enable) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        case (state_d)
            S_RUN:   phase_d = {run_pat_d[5:3] & {3{pwm_on}}, run_pat_d[2:0]};
            S_BRAKE: phase_d = 6'b000_111;
            default: phase_d = 6'b000_000;
        endcase
    end

    // FSM register plus registered outputs, all updated on the same edge.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q      <= S_IDLE;
            tgt_brake_q  <= 1'b0;
            dead_cnt_q   <= '0;
            run_pat_q    <= 6'b000_000;
            phase_enable <= 6'b000_000;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_brake_q  <= tgt_brake_d;
            dead_cnt_q   <= dead_cnt_d;
            run_pat_q    <= run_pat_d;
            phase_enable <= phase_d;
            fault        <= (state_d == S_FAULT);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// Directed bench for bldc_commutation_ctrl at default parameters
// (PWM period 540, dead time 27).
module tb_bldc_commutation_ctrl;

    localparam int DW = 11;

    logic          pclk;
    logic          preset_n;
    logic          enable;
    logic          brake;
    logic          dir;
    logic [DW-1:0] duty;
    logic          clear_fault;
    logic [2:0]    hall_values;
    logic [5:0]    phase_enable;
    logic [2:0]    state;
    logic          fault;
    logic          pwm_sync;

    int vectors;
    int miscompares;

    bldc_commutation_ctrl dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .enable      (enable),
        .brake       (brake),
        .dir         (dir),
        .duty        (duty),
        .clear_fault (clear_fault),
        .hall_values (hall_values),
        .phase_enable(phase_enable),
        .state       (state),
        .fault       (fault),
        .pwm_sync    (pwm_sync)
    );

    // Clock and watchdog.
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Step until the FSM reaches target state s. Count DEAD cycles and any
    // non-zero gate output on the way.
    task automatic wait_state(input logic [2:0] s, input int exp_dead, input string tag);
        int n;
        int dead;
        int nz;
        n = 0;
        dead = 0;
        nz = 0;
        do begin
            step();
            n++;
            if (state == 3'd1) dead++;
            if (state !== s && phase_enable != 6'b0) nz++;
        end while (state !== s && n < 300);
        check({tag, "_reach"}, 32'(state), 32'(s));
        check({tag, "_dead"}, dead, exp_dead);
        check({tag, "_gap_zero"}, nz, 0);
    endtask

    // One PWM period in RUN: count high-side on cycles and confirm the low side is held.
    task automatic run_window(input logic [5:0] hi, input logic [5:0] lo, input int exp_hi,
                              input string tag);
        int hi_n;
        int lo_n;
        int other_n;
        int run_n;
        hi_n = 0;
        lo_n = 0;
        other_n = 0;
        run_n = 0;
        for (int i = 0; i < 540; i++) begin
            step();
            if ((phase_enable & hi) != 6'b0) hi_n++;
            if ((phase_enable & lo) == lo) lo_n++;
            if ((phase_enable & ~(hi | lo)) != 6'b0) other_n++;
            if (state == 3'd2) run_n++;
        end
        check({tag, "_hi_cycles"}, hi_n, exp_hi);
        check({tag, "_lo_cycles"}, lo_n, 540);
        check({tag, "_other_bits"}, other_n, 0);
        check({tag, "_in_run"}, run_n, 540);
    endtask

    // Gate ordering: consecutive non-zero patterns must be the same pattern under PWM.
    logic [5:0] prev_pe;
    initial prev_pe = 6'b0;
    always @(posedge pclk) begin
        logic ok;
        logic [2:0] orh;
        #1;
        if (preset_n && prev_pe != 6'b0 && phase_enable != 6'b0 && prev_pe != phase_enable) begin
            orh = prev_pe[5:3] | phase_enable[5:3];
            ok = (prev_pe[2:0] == phase_enable[2:0]) &&
                 ((orh == prev_pe[5:3]) || (orh == phase_enable[5:3]));
            check("gate_order", 32'(ok), 32'd1);
        end
        prev_pe = phase_enable;
    end

    initial begin
        int n;
        vectors = 0;
        miscompares = 0;
        preset_n = 1'b0;
        enable = 1'b0;
        brake = 1'b0;
        dir = 1'b0;
        duty = 11'd270;
        clear_fault = 1'b0;
        hall_values = 3'b101;

        // Reset state.
        repeat (3) step();
        check("rst_phase", 32'(phase_enable), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_sync", 32'(pwm_sync), 32'd0);

        // Start-up: let the synchroniser settle, then enable.
        @(negedge pclk);
        preset_n = 1'b1;
        repeat (3) step();
        check("idle_state", 32'(state), 32'd0);
        enable = 1'b1;
        wait_state(3'd2, 27, "startup");
        run_window(6'b100_000, 6'b000_010, 270, "ah_bl");

        // Commutation 101 -> 100: DEAD lands on the third edge.
        hall_values = 3'b100;
        step();
        check("comm_e1_state", 32'(state), 32'd2);
        step();
        check("comm_e2_state", 32'(state), 32'd2);
        step();
        check("comm_e3_state", 32'(state), 32'd1);
        check("comm_e3_phase", 32'(phase_enable), 32'd0);
        wait_state(3'd2, 26, "comm");
        run_window(6'b100_000, 6'b000_001, 270, "ah_cl");

        // Back to 101, then reverse direction.
        hall_values = 3'b101;
        repeat (3) step();
        check("back_e3_state", 32'(state), 32'd1);
        wait_state(3'd2, 26, "back");
        dir = 1'b1;
        wait_state(3'd2, 27, "dir");
        run_window(6'b010_000, 6'b000_100, 270, "bh_al");

        // Duty extremes, applied from the next period.
        duty = 11'd0;
        repeat (540) step();
        run_window(6'b010_000, 6'b000_100, 0, "duty0");
        duty = 11'd600;
        repeat (540) step();
        run_window(6'b010_000, 6'b000_100, 540, "duty600");
        duty = 11'd270;

        // Brake from RUN, then release.
        brake = 1'b1;
        wait_state(3'd3, 27, "brake");
        check("brake_phase", 32'(phase_enable), 32'h07);
        brake = 1'b0;
        step();
        check("unbrake_state", 32'(state), 32'd0);
        check("unbrake_phase", 32'(phase_enable), 32'd0);
        wait_state(3'd2, 27, "rerun");

        // Invalid hall in RUN: FAULT on the fourth edge.
        hall_values = 3'b111;
        repeat (3) step();
        check("inv_e3_state", 32'(state), 32'd1);
        step();
        check("fault_state", 32'(state), 32'd4);
        check("fault_flag", 32'(fault), 32'd1);
        check("fault_phase", 32'(phase_enable), 32'd0);
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        step();
        check("clr_en_state", 32'(state), 32'd4);
        check("clr_en_fault", 32'(fault), 32'd1);
        enable = 1'b0;
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        check("clr_state", 32'(state), 32'd0);
        check("clr_fault", 32'(fault), 32'd0);

        // Run again, then assert reset between clock edges.
        hall_values = 3'b101;
        repeat (3) step();
        enable = 1'b1;
        wait_state(3'd2, 27, "prereset");
        repeat (5) step();
        check("pre_rst_low", 32'(phase_enable[2:0]), 32'd4);
        #3;
        preset_n = 1'b0;
        #1;
        check("arst_phase", 32'(phase_enable), 32'd0);
        check("arst_state", 32'(state), 32'd0);
        check("arst_fault", 32'(fault), 32'd0);
        check("arst_sync", 32'(pwm_sync), 32'd0);
        enable = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        preset_n = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!pwm_sync && n < 1000);
        check("sync_first", n, 540);
        step();
        check("sync_width", 32'(pwm_sync), 32'd0);
        n = 1;
        while (!pwm_sync && n < 1000) begin
            step();
            n++;
        end
        check("sync_period", n, 540);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bldc_commutation_ctrl.md
# bldc_commutation_ctrl

Six-step commutation sequencer that drives the `phase_enable` output of the BLDC peripheral. It turns synchronised hall states, a direction command and a duty value into gate enables with PWM on the high side and enforced dead time. Run, brake and fault are sequenced by a state machine, and the block reports state and faults back to the APB register file. It sits between the APB2 BLDC peripheral registers and the gate-driver pins, in the `pclk` domain.

## Interface
- `clk_freq_hz`, default 54_000_000: `pclk` frequency.
- `pwm_freq_hz`, default 100_000: PWM frequency. `pwm_period = clk_freq_hz / pwm_freq_hz`, which is 540 at the defaults.
- `dead_time_cycles`, default 27: all-off cycles inserted before any new conducting pattern. Must be at least 1.
- `duty_width`, default `$clog2(pwm_period)+1`: width of `duty`.

Ports:
- `pclk`, in, 1: clock.
- `preset_n`, in, 1: reset, asynchronous, active-low; clock `pclk`.
- `enable`, in, 1: level; request to run.
- `brake`, in, 1: level; request low-side brake. Takes priority over `enable`.
- `dir`, in, 1: 0 = CW, 1 = CCW.
- `duty`, in, `duty_width`: high-side on-cycles per PWM period. Any value ≥ `pwm_period` gives 100 %.
- `clear_fault`, in, 1: single-cycle pulse that leaves FAULT.
- `hall_values`, in, 3: {A,B,C}, asynchronous to `pclk`.
- `phase_enable`, out, 6: {AH,BH,CH,AL,BL,CL}, registered.
- `state`, out, 3: current FSM state code.
- `fault`, out, 1: high while in FAULT.
- `pwm_sync`, out, 1: one-cycle pulse when the PWM counter equals 0.

## Operation
- **Hall input:** `hall_values` passes through a 2-flop synchroniser to give `hall_s`. Values 000 and 111 are invalid.
- **CW pattern table** (`hall_s` → high/low):
  - 101 → AH/BL
  - 100 → AH/CL
  - 110 → BH/CL
  - 010 → BH/AL
  - 011 → CH/AL
  - 001 → CH/BL
- **CCW pattern:** the same table with the high and low phase letters swapped (101 → BH/AL, etc.).
- **PWM counter:** free-running from 0 to `pwm_period-1`, then wraps to 0. It runs in every state.
- **Gating in RUN:**
  - High-side bit = pattern AND (`pwm_cnt < duty`).
  - Low-side bit = pattern, held continuously.
  - `duty` = 0 gives the high side permanently off.
- **States and outputs:**
  - IDLE = 0: `phase_enable` = 0.
  - DEAD = 1: `phase_enable` = 0; records a target of RUN or BRAKE.
  - RUN = 2: gated pattern as above.
  - BRAKE = 3: `phase_enable` = 000111.
  - FAULT = 4: `phase_enable` = 0.
- **Transitions**, in priority order:
  - From any non-FAULT state, `hall_s` invalid for 2 consecutive cycles while in RUN, or in DEAD with target RUN → FAULT.
  - `brake`=1 in IDLE or RUN → DEAD with target BRAKE.
  - `brake`=1 in DEAD with target RUN → retarget to BRAKE and restart the dead-time counter.
  - BRAKE with `brake`=0 → IDLE. There is no direct BRAKE → RUN transition.
  - IDLE with `enable`=1 and `brake`=0: valid `hall_s` → DEAD with target RUN; invalid `hall_s` → FAULT.
  - RUN with `enable`=0 → IDLE. No dead time is inserted, because turning off is immediate.
  - RUN with a change of pattern (from a `hall_s` change or a `dir` change) → DEAD with target RUN.
  - DEAD: the counter expires after exactly `dead_time_cycles` cycles, then enter the target state.
    - A pattern change during DEAD with target RUN does not restart the counter. RUN uses the pattern current at entry.
    - `enable`=0 during DEAD with target RUN → IDLE.
  - FAULT: `clear_fault`=1 and `enable`=0 → IDLE. `clear_fault` while `enable`=1 is ignored.
- **Duty sampling:** `duty` is sampled only when `pwm_cnt`=0, so a mid-period change takes effect from the next period.

## Timing
- **Reset values:**
  - `phase_enable` = 0, `state` = IDLE, `fault` = 0, `pwm_sync` = 0.
  - `pwm_cnt` = 0, synchroniser = 000, sampled duty = 0.
- **Reset mid-operation:** asynchronous assertion forces all outputs to 0 immediately, independent of the clock.
- **Output registration:** all outputs are registered. `state` and `phase_enable` change on the same `pclk` edge.
- **Hall-change latency:** hall change at edge N lands in `hall_s` at edge N+2; DEAD state and `phase_enable`=0 follow at edge N+3. The new pattern appears at edge N+3+`dead_time_cycles`.
- **Gate ordering:** `phase_enable` never goes directly from one non-zero pattern to a different non-zero pattern, except through RUN PWM gating of the same pattern.
- **`pwm_sync`:** high exactly one cycle in every `pwm_period` cycles.
- **Simultaneous `enable` rise and invalid hall:** FAULT wins.
- **Simultaneous `brake` and `enable`:** BRAKE path wins.

## Test plan
- **Reset start-up:** reset, then `enable`=1, `dir`=0, hall=101, `duty`=270 → `phase_enable`=0 for 27 cycles. Then AH+BL with AH high for 270 of 540 cycles, BL constant.
- **Commutation:** while running, hall 101→100 → 27 cycles of 000000, then AH/CL (100001 gated). Check no cycle has two different non-zero patterns back-to-back.
- **Direction and duty:** `dir` toggles to 1 with hall=101 → dead gap, then BH/AL. `duty` 0 → high side never asserted. `duty`=600 → high side always asserted.
- **Brake:** `brake`=1 during RUN → 27 zero cycles, then 000111 and `state`=3. `brake`=0 → IDLE and 000000.
- **Fault:** hall=111 held 2 cycles in RUN → `fault`=1, `state`=4, outputs 0. `clear_fault` with `enable`=1 → no change. `clear_fault` with `enable`=0 → IDLE.
- **Async reset:** `preset_n` low mid-PWM-period → all outputs 0 without a clock edge. After release, `pwm_sync` first pulses 540 cycles later.
